div_req_sched: RTL and testbench

- Two-requester scheduler that shares one Periferico_DIVISOR instance.
- Arbitrates round-robin between requesters and drives the peripheral's bus side (cs/wr/rd/addr/d_in).
- Sequence per job: write DV, write DR, write START, poll DONE, read result, return the quotient with a one-cycle ack.
- Sits between the calculator control logic and the divider peripheral.

---
 rtl/div_sched_pkg.sv | 29 ++
 rtl/div_rr_arb.sv | 36 +++
 rtl/div_req_sched.sv | 168 ++++++++++++++++
 tb/tb_div_req_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider request scheduler: FSM state codes,
// default peripheral register map and the error quotient.
package div_sched_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_GRANT    = 4'd1;
    localparam logic [3:0] S_WR_DV    = 4'd2;
    localparam logic [3:0] S_WR_DR    = 4'd3;
    localparam logic [3:0] S_WR_START = 4'd4;
    localparam logic [3:0] S_POLL_RD  = 4'd5;
    localparam logic [3:0] S_POLL_CHK = 4'd6;
    localparam logic [3:0] S_RD_RES   = 4'd7;
    localparam logic [3:0] S_RES_CAP  = 4'd8;
    localparam logic [3:0] S_RESP     = 4'd9;

    localparam logic [4:0] DEF_ADDR_DV    = 5'h04;
    localparam logic [4:0] DEF_ADDR_DR    = 5'h08;
    localparam logic [4:0] DEF_ADDR_START = 5'h0C;
    localparam logic [4:0] DEF_ADDR_RES   = 5'h10;
    localparam logic [4:0] DEF_ADDR_DONE  = 5'h14;

    localparam int         DONE_BIT = 0;
    localparam logic [15:0] ERR_QUOT = 16'hFFFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Two-way round-robin arbiter; the priority pointer starts at requester 0
// and toggles on every advance pulse.
module div_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       vld
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = advance ? ~ptr_q : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer only matters when both requesters contend.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        vld = |req;
    end

endmodule

// File: rtl/div_req_sched.sv
// Shares one divider peripheral between two requesters: write DV, DR, START,
// poll DONE, read result, ack. Define DIV_ZERO_CHECK_EN to short-circuit zero divisors.
module div_req_sched
    import div_sched_pkg::*;
#(
    parameter logic [4:0] ADDR_DV    = DEF_ADDR_DV,
    parameter logic [4:0] ADDR_DR    = DEF_ADDR_DR,
    parameter logic [4:0] ADDR_START = DEF_ADDR_START,
    parameter logic [4:0] ADDR_RES   = DEF_ADDR_RES,
    parameter logic [4:0] ADDR_DONE  = DEF_ADDR_DONE,
    parameter int         TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] dv0,
    input  logic [15:0] dv1,
    input  logic [15:0] dr0,
    input  logic [15:0] dr1,
    output logic [1:0]  ack,
    output logic [15:0] result,
    output logic        err,
    output logic        busy,
    output logic        bus_cs,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [4:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [3:0]  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [15:0] dv_q, dv_d;
    logic [15:0] dr_q, dr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;

    logic [1:0]  arb_gnt;
    logic        arb_vld;
    logic        arb_adv;

    assign arb_adv = (state_q == S_RESP);

    div_rr_arb u_arb (
        .clk     (CLK),
        .rst_n   (reset),
        .req     (req),
        .advance (arb_adv),
        .gnt     (arb_gnt),
        .vld     (arb_vld)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            dv_q     <= 16'd0;
            dr_q     <= 16'd0;
            cnt_q    <= 8'd0;
            result_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            dv_q     <= dv_d;
            dr_q     <= dr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // result/err are loaded only on the transition into RESP so they hold between jobs.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        dv_d     = dv_q;
        dr_d     = dr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (!arb_vld) begin
                    state_d = S_IDLE;
                end else begin
                    gnt_d   = arb_gnt;
                    dv_d    = arb_gnt[1] ? dv1 : dv0;
                    dr_d    = arb_gnt[1] ? dr1 : dr0;
                    state_d = S_WR_DV;
`ifdef DIV_ZERO_CHECK_EN
                    if ((arb_gnt[1] ? dr1 : dr0) == 16'd0) begin
                        state_d  = S_RESP;
                        result_d = ERR_QUOT;
                        err_d    = 1'b1;
                    end
`endif
                end
            end
            S_WR_DV:    state_d = S_WR_DR;
            S_WR_DR:    state_d = S_WR_START;
            S_WR_START: begin
                cnt_d   = 8'd0;
                state_d = S_POLL_RD;
            end
            S_POLL_RD:  state_d = S_POLL_CHK;
            S_POLL_CHK: begin
                if (bus_rdata[DONE_BIT]) begin
                    state_d = S_RD_RES;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d  = S_RESP;
                    result_d = 16'd0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d   = sat_inc8(cnt_q);
                    state_d = S_POLL_RD;
                end
            end
            S_RD_RES:   state_d = S_RES_CAP;
            S_RES_CAP: begin
                result_d = bus_rdata;
                err_d    = 1'b0;
                state_d  = S_RESP;
            end
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_cs    = 1'b0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = 5'd0;
        bus_wdata = 16'd0;
        ack       = 2'b00;
        case (state_q)
            S_WR_DV: begin
                bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_DV; bus_wdata = dv_q;
            end
            S_WR_DR: begin
                bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_DR; bus_wdata = dr_q;
            end
            S_WR_START: begin
                bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = ADDR_START; bus_wdata = 16'd1;
            end
            S_POLL_RD: begin
                bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = ADDR_DONE;
            end
            S_RD_RES: begin
                bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = ADDR_RES;
            end
            S_RESP:  ack = gnt_q;
            default: ;
        endcase
        busy   = (state_q != S_IDLE);
        result = result_q;
        err    = err_q;
    end

endmodule

// File: tb/tb_div_req_sched.sv
// Directed bench for div_req_sched with a behavioural divider peripheral that
// answers DONE after a programmable number of polls.
module tb_div_req_sched;

    localparam int TO = 4;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] dv0, dv1, dr0, dr1;
    logic [1:0]  ack;
    logic [15:0] result;
    logic        err, busy;
    logic        bus_cs, bus_wr, bus_rd;
    logic [4:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    always #5 clk = ~clk;

    div_req_sched #(.TIMEOUT(TO)) dut (
        .CLK(clk), .reset(reset), .req(req),
        .dv0(dv0), .dv1(dv1), .dr0(dr0), .dr1(dr1),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // Peripheral model: registered read data, DONE after done_polls failed polls (-1 = never).
    logic [15:0] m_dv = 16'd0, m_dr = 16'd1, rdata = 16'd0;
    int          m_polls = 0;
    int          done_polls = 0;
    int          cyc = 0;
    int          done_reads = 0;
    logic [4:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];

    assign bus_rdata = rdata;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_cs && bus_wr) begin
            wr_addr_q.push_back(bus_addr);
            wr_data_q.push_back(bus_wdata);
            wr_cyc_q.push_back(cyc);
            case (bus_addr)
                5'h04: m_dv <= bus_wdata;
                5'h08: m_dr <= bus_wdata;
                5'h0C: m_polls <= 0;
                default: ;
            endcase
        end
        if (bus_cs && bus_rd) begin
            if (bus_addr == 5'h14) begin
                rdata <= {15'd0, (done_polls >= 0) && (m_polls >= done_polls)};
                m_polls <= m_polls + 1;
                done_reads <= done_reads + 1;
            end else if (bus_addr == 5'h10) begin
                rdata <= (m_dr == 16'd0) ? 16'hFFFF : m_dv / m_dr;
            end
        end
    end

    int   grant_cyc = 0;
    int   ack_seen = 0;
    int   viol = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (busy && !busy_prev) grant_cyc <= cyc;
        busy_prev <= busy;
        if (|ack) ack_seen <= ack_seen + 1;
        if ((bus_cs && (bus_wr == bus_rd)) || (!bus_cs && (bus_wr || bus_rd)))
            viol <= viol + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output logic [1:0] a, output int lat);
        a = 2'b00;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (|ack) begin
                a = ack;
                lat = cyc - grant_cyc + 1;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic [1:0]  req;
        logic [15:0] dv0, dr0, dv1, dr1;
        int          dp;
        logic [1:0]  ack;
        logic [15:0] res;
        logic        err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        logic [1:0]  a;
        logic [15:0] sdv, sdr;
        int          lat, w0, d0, nw, exp_p, exp_lat, exp_w, a0, found;
        bit          zskip;
        vec_t        v;

        //                req    dv0       dr0     dv1        dr1     dp  ack    res           err
        vecs[0]  = '{2'b01, 16'd900,  16'd5,  16'd0,     16'd1,  2,  2'b01, 16'd180,      1'b0};
        vecs[1]  = '{2'b10, 16'd0,    16'd1,  16'd1000,  16'd10, 0,  2'b10, 16'd100,      1'b0};
        vecs[2]  = '{2'b11, 16'd100,  16'd7,  16'd1000,  16'd10, 1,  2'b01, 16'd14,       1'b0};
        vecs[3]  = '{2'b10, 16'd100,  16'd7,  16'd1000,  16'd10, 0,  2'b10, 16'd100,      1'b0};
        vecs[4]  = '{2'b11, 16'd100,  16'd7,  16'd1000,  16'd10, 0,  2'b01, 16'd14,       1'b0};
        vecs[5]  = '{2'b11, 16'd100,  16'd7,  16'd1000,  16'd10, 0,  2'b10, 16'd100,      1'b0};
        vecs[6]  = '{2'b11, 16'd100,  16'd7,  16'd1000,  16'd10, 0,  2'b01, 16'd14,       1'b0};
        vecs[7]  = '{2'b11, 16'd100,  16'd7,  16'd1000,  16'd10, 0,  2'b10, 16'd100,      1'b0};
        vecs[8]  = '{2'b01, 16'd50,   16'd3,  16'd0,     16'd1,  -1, 2'b01, 16'd0,        1'b1};
        vecs[9]  = '{2'b10, 16'd0,    16'd1,  16'd65535, 16'd1,  3,  2'b10, 16'd65535,    1'b0};
        vecs[10] = '{2'b01, 16'd0,    16'd9,  16'd0,     16'd1,  0,  2'b01, 16'd0,        1'b0};
        vecs[11] = '{2'b10, 16'd0,    16'd1,  16'd1234,  16'd0,  0,  2'b10, 16'hFFFF,     ZCHK};
        vecs[12] = '{2'b01, 16'd7,    16'd7,  16'd0,     16'd1,  4,  2'b01, 16'd1,        1'b0};

        reset = 1'b0;
        req = 2'b00;
        dv0 = '0; dv1 = '0; dr0 = 16'd1; dr1 = 16'd1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {ack, err, busy, bus_cs, bus_wr, bus_rd, bus_addr, bus_wdata}, 64'd0);
        chk("reset_result", result, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            req = v.req;
            dv0 = v.dv0; dr0 = v.dr0; dv1 = v.dv1; dr1 = v.dr1;
            done_polls = v.dp;
            w0 = wr_addr_q.size();
            d0 = done_reads;
            wait_ack(a, lat);
            req = req & ~a;

            sdv = v.ack[0] ? v.dv0 : v.dv1;
            sdr = v.ack[0] ? v.dr0 : v.dr1;
            zskip = ZCHK && (sdr == 16'd0);
            exp_p = zskip ? 0 : ((v.dp < 0) ? TO + 1 : v.dp + 1);
            exp_lat = zskip ? 2 : ((v.dp < 0) ? 5 + 2 * exp_p : 7 + 2 * exp_p);
            exp_w = zskip ? 0 : 3;

            chk($sformatf("v%0d_ack", i), a, v.ack);
            chk($sformatf("v%0d_result", i), result, v.res);
            chk($sformatf("v%0d_err", i), err, v.err);
            chk($sformatf("v%0d_latency", i), lat, exp_lat);
            chk($sformatf("v%0d_done_reads", i), done_reads - d0, exp_p);
            nw = wr_addr_q.size() - w0;
            chk($sformatf("v%0d_writes", i), nw, exp_w);
            if (nw == 3 && exp_w == 3) begin
                chk($sformatf("v%0d_wr_dv", i), {wr_addr_q[w0], wr_data_q[w0]}, {5'h04, sdv});
                chk($sformatf("v%0d_wr_dr", i), {wr_addr_q[w0+1], wr_data_q[w0+1]}, {5'h08, sdr});
                chk($sformatf("v%0d_wr_start", i), {wr_addr_q[w0+2], wr_data_q[w0+2]}, {5'h0C, 16'd1});
                chk($sformatf("v%0d_wr_consec", i), wr_cyc_q[w0+2] - wr_cyc_q[w0], 2);
            end
        end

        // Reset while polling: everything clears at once, no ack, then the same request reruns.
        @(negedge clk);
        req = 2'b01; dv0 = 16'd20; dr0 = 16'd4;
        done_polls = -1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_rd && bus_addr == 5'h14) begin
                found = 1;
                break;
            end
        end
        chk("midrst_reach_poll", found, 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_ctrl", {ack, err, busy, bus_cs, bus_wr, bus_rd, bus_addr, bus_wdata}, 64'd0);
        chk("midrst_result", result, 64'd0);
        a0 = ack_seen;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_ack", ack_seen - a0, 0);
        @(negedge clk);
        done_polls = 0;
        reset = 1'b1;
        wait_ack(a, lat);
        req = req & ~a;
        chk("midrst_rerun_ack", a, 2'b01);
        chk("midrst_rerun_result", result, 16'd5);
        chk("midrst_rerun_err", err, 1'b0);
        chk("midrst_rerun_latency", lat, 9);

        repeat (2) @(negedge clk);
        chk("bus_strobe_protocol", viol, 0);
        chk("idle_after_all", {busy, ack}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
